// File: rtl/if_fetch_pkg.sv
// Shared constants and the fetch-buffer entry type for the instruction fetch stage.
package if_fetch_pkg;

   localparam logic [31:0] INST_NOP     = 32'h0000_0013;  // ADDI x0,x0,0, shared with decode
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        filled;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Reservation FIFO: entries are reserved at grant with their address and
// filled in order as responses return; only filled heads are consumed.
module fetch_fifo
   import if_fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          reserve,
   input  logic [31:0]   reserve_addr,
   input  logic          fill,
   input  logic [31:0]   fill_data,
   input  logic          pop,
   output logic [31:0]   head_addr,
   output logic [31:0]   head_data,
   output logic          head_filled,
   output logic [CW-1:0] count
);

   fetch_entry_t    ent [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr, fill_ptr;

   assign head_addr   = ent[rd_ptr].addr;
   assign head_data   = ent[rd_ptr].data;
   assign head_filled = ent[rd_ptr].filled;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fill_ptr <= '0;
         count    <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) ent[i].filled <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fill_ptr <= '0;
         count    <= '0;
      end else begin
         // Reserve and pop may hit the same slot when full; pop reads the old contents.
         if (reserve) begin
            ent[wr_ptr].addr   <= reserve_addr;
            ent[wr_ptr].filled <= 1'b0;
            wr_ptr             <= wr_ptr + 1'b1;
         end
         if (fill) begin
            ent[fill_ptr].data   <= fill_data;
            ent[fill_ptr].filled <= 1'b1;
            fill_ptr             <= fill_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(reserve) - CW'(pop);
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the pc, issues in-order word fetches and
// feeds decode from a reservation FIFO, discarding wrong-path returns.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold_flag_i,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o
);

   localparam int           CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0]  DEPTH_W = (CW + 1)'(DEPTH);

   logic [31:0]   pc, last_addr, head_addr, head_data, jump_tgt;
   logic [CW-1:0] outstanding, discard, fifo_count;
   logic [CW:0]   in_use;
   logic          head_filled, head_valid, grant, rsp, fill, pop;

   assign jump_tgt     = jump_addr_i & ~32'h3;
   assign head_valid   = (fifo_count != '0) && head_filled;
   assign inst_valid_o = head_valid && !jump_en_i;
   assign pop          = inst_valid_o && !hold_flag_i;

   // Reserved entries plus wrong-path fetches equals buffered plus in-flight;
   // the slot freed by this cycle's pop is counted as available.
   assign in_use      = {1'b0, fifo_count} + {1'b0, discard} - {{CW{1'b0}}, pop};
   assign ibus_req_o  = rst_n && (in_use < DEPTH_W);
   assign ibus_addr_o = pc;
   assign grant       = ibus_req_o && ibus_gnt_i;

   // A response with nothing outstanding is ignored so the counters never underflow.
   assign rsp  = ibus_rvalid_i && (outstanding != '0);
   assign fill = rsp && (discard == '0) && !jump_en_i;

   assign inst_o      = inst_valid_o ? head_data : INST_NOP;
   assign inst_addr_o = (fifo_count != '0) ? head_addr : last_addr;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (jump_en_i),
      .reserve      (grant && !jump_en_i),
      .reserve_addr (pc),
      .fill         (fill),
      .fill_data    (ibus_rdata_i),
      .pop          (pop),
      .head_addr    (head_addr),
      .head_data    (head_data),
      .head_filled  (head_filled),
      .count        (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         last_addr   <= ZERO_WORD;
      end else begin
         outstanding <= outstanding + CW'(grant) - CW'(rsp);
         if (jump_en_i) begin
            // Everything still in flight after this cycle, including a same-cycle grant, is wrong-path.
            pc      <= jump_tgt;
            discard <= outstanding + CW'(grant) - CW'(rsp);
         end else begin
            if (grant) pc <= pc + 32'd4;
            if (rsp && discard != '0) discard <= discard - 1'b1;
         end
         if (pop) last_addr <= head_addr;
      end
   end

   a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      ibus_rvalid_i |-> outstanding != '0);

endmodule
